raman_acq_sequencer: RTL and testbench

Acquisition sequencer directly upstream of the Raman accumulator. It fires the laser at a fixed shot period and emits the one-cycle `enable` start pulse that opens each accumulation pass. After a blanking delay it forwards a window of registered ADC samples with a point index, and runs a Stokes shot block followed by an anti-Stokes shot block selected by `switch`.

---
 rtl/raman_acq_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_raman_acq_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/raman_acq_sequencer.sv
// rtl/raman_acq_sequencer.sv - laser shot and capture-window sequencer feeding the Raman accumulator
// Optional feature macro: RAMAN_ACQ_OFFSET_EN adds a per-shot offset subtraction on data.
module raman_acq_sequencer #(
    parameter int POINTS = 1500,
    parameter int DELAY  = 2,
    parameter int PERIOD = 2000,
    parameter int SHOTS  = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [11:0] adc_data,
`ifdef RAMAN_ACQ_OFFSET_EN
    input  logic [11:0] offset,
`endif
    output logic        laser_fire,
    output logic        enable,
    output logic [11:0] data,
    output logic        data_valid,
    output logic [10:0] cnt_point,
    output logic [16:0] cnt_measure,
    output logic        switch,
    output logic        busy,
    output logic        done
);

    localparam int PW = $clog2(PERIOD);

    // Period counter value at the last cycle of each phase; FIRE is always at 0.
    localparam logic [PW-1:0] BLANK_LAST = PW'(DELAY);
    localparam logic [PW-1:0] CAP_LAST   = PW'(DELAY + POINTS);
    localparam logic [PW-1:0] PER_LAST   = PW'(PERIOD - 1);
    localparam logic [10:0]   PT_LAST    = 11'(POINTS - 1);
    localparam logic [16:0]   SHOT_LAST  = 17'(SHOTS - 1);

    generate
        if (PERIOD < POINTS + DELAY + 2) begin : g_period_check
            $error("raman_acq_sequencer: PERIOD must be at least POINTS + DELAY + 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_FIRE,
        S_BLANK,
        S_CAPTURE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] pcnt;
    logic          shot_end;

    assign shot_end = (state == S_WAIT) && (pcnt == PER_LAST);

    // State register; reset discards any in-flight shot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection and state-decoded outputs.
    always_comb begin
        state_next = state;
        laser_fire = 1'b0;
        enable     = 1'b0;
        data_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (run) state_next = S_FIRE;
            end
            S_FIRE: begin
                laser_fire = 1'b1;
                enable     = 1'b1;
                busy       = 1'b1;
                state_next = (DELAY == 0) ? S_CAPTURE : S_BLANK;
            end
            S_BLANK: begin
                busy = 1'b1;
                if (pcnt == BLANK_LAST) state_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                busy       = 1'b1;
                data_valid = 1'b1;
                if (pcnt == CAP_LAST) state_next = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (shot_end) begin
                    if (!run) begin
                        state_next = S_IDLE;
                    end else if (cnt_measure != SHOT_LAST || !switch) begin
                        state_next = S_FIRE;
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (!run) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Period counter: zero in FIRE, stops at PERIOD-1 so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (state_next == S_FIRE) begin
            pcnt <= '0;
        end else if (busy && pcnt != PER_LAST) begin
            pcnt <= pcnt + 1'b1;
        end
    end

    // Shot counter and channel select; both only move at a shot boundary or on start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_measure <= '0;
            switch      <= 1'b0;
        end else if (state == S_IDLE && run) begin
            cnt_measure <= '0;
            switch      <= 1'b0;
        end else if (shot_end) begin
            if (run && cnt_measure == SHOT_LAST && !switch) begin
                switch      <= 1'b1;
                cnt_measure <= '0;
            end else begin
                cnt_measure <= cnt_measure + 1'b1;
            end
        end
    end

    // Point index: restarts on window entry, saturates at POINTS-1 and holds outside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_point <= '0;
        end else if (state_next == S_CAPTURE && state != S_CAPTURE) begin
            cnt_point <= '0;
        end else if (state == S_CAPTURE && cnt_point != PT_LAST) begin
            cnt_point <= cnt_point + 1'b1;
        end
    end

`ifdef RAMAN_ACQ_OFFSET_EN
    logic [11:0] offset_q;
    logic [11:0] offset_eff;

    // In FIRE the live offset is used so a zero-delay capture already sees it.
    assign offset_eff = (state == S_FIRE) ? offset : offset_q;

    // Offset is latched once per shot in FIRE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            offset_q <= '0;
        end else if (state == S_FIRE) begin
            offset_q <= offset;
        end
    end

    // Sample register with saturating offset subtraction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else begin
            data <= (adc_data >= offset_eff) ? (adc_data - offset_eff) : '0;
        end
    end
`else
    // Sample register: one-cycle delayed copy of the ADC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else begin
            data <= adc_data;
        end
    end
`endif

endmodule

// File: tb/tb_raman_acq_sequencer.sv
// tb/tb_raman_acq_sequencer.sv - directed self-checking bench for raman_acq_sequencer
module tb_raman_acq_sequencer;

    localparam int POINTS = 10;
    localparam int DELAY  = 2;
    localparam int PERIOD = 40;
    localparam int SHOTS  = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [11:0] adc_data;
`ifdef RAMAN_ACQ_OFFSET_EN
    logic [11:0] offset;
`endif
    logic        laser_fire;
    logic        enable;
    logic [11:0] data;
    logic        data_valid;
    logic [10:0] cnt_point;
    logic [16:0] cnt_measure;
    logic        switch;
    logic        busy;
    logic        done;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          cyc    = 0;
    logic [11:0] prev_adc;

    always #5 clk = ~clk;

    raman_acq_sequencer #(
        .POINTS (POINTS),
        .DELAY  (DELAY),
        .PERIOD (PERIOD),
        .SHOTS  (SHOTS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .adc_data    (adc_data),
`ifdef RAMAN_ACQ_OFFSET_EN
        .offset      (offset),
`endif
        .laser_fire  (laser_fire),
        .enable      (enable),
        .data        (data),
        .data_valid  (data_valid),
        .cnt_point   (cnt_point),
        .cnt_measure (cnt_measure),
        .switch      (switch),
        .busy        (busy),
        .done        (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Advance to the next falling edge; remember the sample the DUT just registered.
    task automatic tick();
        @(negedge clk);
        prev_adc = adc_data;
        cyc++;
        adc_data = 12'(cyc);
    endtask

    initial begin
        rst_n    = 1'b1;
        run      = 1'b1;
        adc_data = '0;
        prev_adc = '0;
`ifdef RAMAN_ACQ_OFFSET_EN
        offset   = 12'd100;
`endif
        #1 rst_n = 1'b0;

        // Reset held with run high: everything quiet.
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_ctl", {laser_fire, enable, data_valid, switch, busy, done}, 0);
            check("rst_data", data, 0);
            check("rst_cnt", {cnt_point, cnt_measure}, 0);
        end

        run   = 1'b0;
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_busy", busy, 0);
        check("idle_fire", laser_fire, 0);

        // Single shot followed by the full two-channel run; k=0 is the FIRE cycle.
        run = 1'b1;
        for (int k = 0; k < 260; k++) begin
            int j;
            bit act;
            bit win;
            j   = k % PERIOD;
            act = (k < 2 * SHOTS * PERIOD);
            win = act && (j >= 3) && (j <= 12);
            tick();
            check("fr_enable", enable, act && j == 0);
            check("fr_fire", laser_fire, act && j == 0);
            check("fr_valid", data_valid, win);
            check("fr_point", cnt_point, (k < 3) ? 0 : (win ? j - 3 : 9));
            if (win) check("fr_data", data, prev_adc);
            check("fr_measure", cnt_measure, act ? (k / 40) % 3 : 3);
            check("fr_switch", switch, k >= 120);
            check("fr_busy", busy, act);
            check("fr_done", done, !act);
        end

        run = 1'b0;
        tick();
        check("done_exit", done, 0);
        check("done_exit_busy", busy, 0);

        // Abort: run dropped during the capture of shot 2.
        run = 1'b1;
        for (int k = 0; k < 120; k++) begin
            int j;
            j = k % PERIOD;
            tick();
            check("ab_enable", enable, k == 0 || k == 40);
            check("ab_valid", data_valid, (k < 80) && (j >= 3) && (j <= 12));
            check("ab_busy", busy, k < 80);
            check("ab_measure", cnt_measure, (k < 40) ? 0 : ((k < 80) ? 1 : 2));
            check("ab_switch", switch, 0);
            if (k == 45) run = 1'b0;
        end

        // Reset pulse during shot 4 (anti-Stokes), in the capture window.
        run = 1'b1;
        for (int k = 0; k <= 130; k++) begin
            tick();
            check("mr_enable", enable, (k % 40) == 0);
        end
        check("mr_pre_switch", switch, 1);
        check("mr_pre_valid", data_valid, 1);
        rst_n = 1'b0;
        run   = 1'b0;
        #1;
        check("mr_async_valid", data_valid, 0);
        check("mr_switch", switch, 0);
        check("mr_measure", cnt_measure, 0);
        check("mr_busy", busy, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("mr_idle_fire", laser_fire, 0);
        run = 1'b1;
        tick();
        check("mr_restart_fire", laser_fire, 1);
        check("mr_restart_switch", switch, 0);
        check("mr_restart_measure", cnt_measure, 0);
        for (int k = 1; k <= 40; k++) begin
            tick();
            check("mr_run_switch", switch, 0);
            check("mr_run_enable", enable, k == 40);
        end

`ifdef RAMAN_ACQ_OFFSET_EN
        // Offset 100: shot 0 sees 91..100 -> 0, shot 1 sees 101..110 -> 1..10.
        rst_n  = 1'b0;
        run    = 1'b0;
        offset = 12'd100;
        tick();
        rst_n = 1'b1;
        tick();
        run = 1'b1;
        for (int k = 0; k < 80; k++) begin
            int j;
            int s;
            j = k % PERIOD;
            s = k / PERIOD;
            tick();
            if (j >= 3 && j <= 12) check("off_data", data, (s == 0) ? 0 : j - 2);
            adc_data = 12'(91 + 10 * s + j - 2);
            if (k == 5) offset = 12'd7;
            if (k == 30) offset = 12'd100;
        end
        run = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
